// File: rtl/msrv32_csr_pkg.sv
// Shared CSR definitions for the msrv32 CSR file and its attached banks:
// HPM base addresses, CSR op encodings and the read-modify-write operator.
package msrv32_csr_pkg;

   localparam logic [11:0] HPMCOUNTER_BASE  = 12'hB03;
   localparam logic [11:0] HPMCOUNTERH_BASE = 12'hB83;
   localparam logic [11:0] HPMEVENT_BASE    = 12'h323;
   localparam int          OF_BIT           = 31;

   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   function automatic logic [31:0] csr_alu(input csr_op_e     op,
                                           input logic [31:0] old,
                                           input logic [31:0] operand);
      case (op)
         CSR_OP_WRITE: csr_alu = operand;
         CSR_OP_SET:   csr_alu = old | operand;
         CSR_OP_CLEAR: csr_alu = old & ~operand;
         default:      csr_alu = old;
      endcase
   endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One HPM counter: event selector/OF register, stage-1 event flop and the
// CNT_WIDTH counter with write-wins-over-increment and sticky overflow.
module hpm_counter_slice
   import msrv32_csr_pkg::*;
#(
   parameter int CNT_WIDTH = 64,
   parameter int NUM_EVT   = 8,
   parameter int EVT_SEL_W = 5
) (
   input  logic               clock,
   input  logic               rst_in,
   input  logic [NUM_EVT-1:0] events,
   input  logic               inhibit,
   input  logic               wr_lo,
   input  logic               wr_hi,
   input  logic               wr_evt,
   input  logic [31:0]        wdata,
   output logic [31:0]        cnt_lo,
   output logic [31:0]        cnt_hi,
   output logic [31:0]        evt_rd,
   output logic               ovf
);

   logic [EVT_SEL_W-1:0] sel;
   logic                 evt_p1;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [63:0]          cnt_ext;
   logic [63:0]          cnt_nxt;
   logic                 evt_hit;
   logic                 wrap;

   // Selector 0 and out-of-range selectors leave evt_hit low.
   always_comb begin
      evt_hit = 1'b0;
      for (int k = 1; k <= NUM_EVT; k++) begin
         if (k < (1 << EVT_SEL_W) && sel == EVT_SEL_W'(k)) evt_hit = events[k-1];
      end
   end

   assign cnt_ext = 64'(cnt);
   assign cnt_inc = cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   assign wrap    = evt_p1 & ~wr_lo & ~wr_hi & (&cnt);

   // A half-write replaces the increment outright; the other half is held.
   always_comb begin
      cnt_nxt = cnt_ext;
      if (wr_lo)       cnt_nxt[31:0]  = wdata;
      else if (wr_hi)  cnt_nxt[63:32] = wdata;
      else if (evt_p1) cnt_nxt        = 64'(cnt_inc);
   end

   always_ff @(posedge clock or negedge rst_in) begin
      if (!rst_in) begin
         sel    <= '0;
         ovf    <= 1'b0;
         evt_p1 <= 1'b0;
         cnt    <= '0;
      end else begin
         // stage 1: sample selected event, gated by inhibit
         evt_p1 <= evt_hit & ~inhibit;
         // stage 2: counter update
         cnt    <= cnt_nxt[CNT_WIDTH-1:0];
         if (wr_evt) begin
            sel <= wdata[EVT_SEL_W-1:0];
            ovf <= wdata[OF_BIT];
         end else if (wrap) begin
            ovf <= 1'b1;
         end
      end
   end

   assign cnt_lo = cnt_ext[31:0];
   assign cnt_hi = cnt_ext[63:32];

   always_comb begin
      evt_rd                  = '0;
      evt_rd[EVT_SEL_W-1:0]   = sel;
      evt_rd[OF_BIT]          = ovf;
   end

endmodule

// File: rtl/msrv32_hpm_counter_bank.sv
// Bank of mhpmcounter/mhpmevent registers: address decode, CSR write-op ALU,
// read mux ORed into the CSR file, and the registered overflow interrupt.
module msrv32_hpm_counter_bank
   import msrv32_csr_pkg::*;
#(
   parameter int NUM_CNT   = 4,
   parameter int CNT_WIDTH = 64,
   parameter int NUM_EVT   = 8,
   parameter int EVT_SEL_W = 5
) (
   input  logic               clock,
   input  logic               rst_in,
   input  logic               wr_en_in,
   input  logic [11:0]        csr_addr_in,
   input  logic [1:0]         csr_op_in,
   input  logic [31:0]        csr_wdata_in,
   input  logic [NUM_EVT-1:0] event_in,
   input  logic [NUM_CNT-1:0] inhibit_in,
   output logic [31:0]        csr_data_out,
   output logic               csr_hit_out,
   output logic [NUM_CNT-1:0] ovf_vec_out,
   output logic               ovf_irq_out
);

   localparam bit HI_IMPL = (CNT_WIDTH > 32);

   csr_op_e            op;
   logic               wr_act;
   logic [NUM_CNT-1:0] hit_lo;
   logic [NUM_CNT-1:0] hit_hi;
   logic [NUM_CNT-1:0] hit_evt;
   logic [31:0]        rd_data;
   logic [31:0]        new_val;
   logic [31:0]        cnt_lo  [NUM_CNT];
   logic [31:0]        cnt_hi  [NUM_CNT];
   logic [31:0]        evt_rd  [NUM_CNT];

   assign op = csr_op_e'(csr_op_in);

   always_comb begin
      hit_lo  = '0;
      hit_hi  = '0;
      hit_evt = '0;
      rd_data = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         hit_lo[i]  = (csr_addr_in == 12'(HPMCOUNTER_BASE + i));
         hit_hi[i]  = (csr_addr_in == 12'(HPMCOUNTERH_BASE + i));
         hit_evt[i] = (csr_addr_in == 12'(HPMEVENT_BASE + i));
         if (hit_lo[i])  rd_data = rd_data | cnt_lo[i];
         if (hit_hi[i])  rd_data = rd_data | cnt_hi[i];
         if (hit_evt[i]) rd_data = rd_data | evt_rd[i];
      end
   end

   assign csr_hit_out  = |{hit_lo, hit_hi, hit_evt};
   assign csr_data_out = rd_data;
   assign wr_act       = wr_en_in & (op != CSR_OP_NONE);
   assign new_val      = csr_alu(op, rd_data, csr_wdata_in);

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_slice
      hpm_counter_slice #(
         .CNT_WIDTH (CNT_WIDTH),
         .NUM_EVT   (NUM_EVT),
         .EVT_SEL_W (EVT_SEL_W)
      ) u_slice (
         .clock   (clock),
         .rst_in  (rst_in),
         .events  (event_in),
         .inhibit (inhibit_in[g]),
         .wr_lo   (wr_act & hit_lo[g]),
         // a 32-bit counter has no high half to write
         .wr_hi   (wr_act & hit_hi[g] & HI_IMPL),
         .wr_evt  (wr_act & hit_evt[g]),
         .wdata   (new_val),
         .cnt_lo  (cnt_lo[g]),
         .cnt_hi  (cnt_hi[g]),
         .evt_rd  (evt_rd[g]),
         .ovf     (ovf_vec_out[g])
      );
   end

   always_ff @(posedge clock or negedge rst_in) begin
      if (!rst_in) ovf_irq_out <= 1'b0;
      else         ovf_irq_out <= |ovf_vec_out;
   end

endmodule

// File: doc/msrv32_hpm_counter_bank.md
Name: msrv32_hpm_counter_bank

Overview:
Parametrised bank of RISC-V machine hardware-performance-monitor counters (mhpmcounter3.., mhpmcounter3h.., mhpmevent3..). Each counter has a software event selector, per-counter inhibit and a sticky overflow flag that raises a local counter-overflow interrupt. It sits alongside the CSR file's fixed mcycle/minstret counters, shares its CSR address/op bus, and its read data is ORed into the CSR read mux under csr_hit_out.

Parameters:
NUM_CNT, 4, number of HPM counters (1..29), mapped to indices 3..3+NUM_CNT-1
CNT_WIDTH, 64, implemented counter width (32..64); unimplemented upper bits read 0
NUM_EVT, 8, number of event inputs; selector value k in 1..NUM_EVT selects event_in[k-1]
EVT_SEL_W, 5, implemented width of mhpmevent selector field

Ports:
clock  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
wr_en_in  in  1  CSR write strobe
csr_addr_in  in  12  CSR address
csr_op_in  in  2  01 write, 10 set, 11 clear, 00 no write
csr_wdata_in  in  32  write operand (rs1 or zero-extended uimm)
event_in  in  NUM_EVT  per-cycle event pulses, 1 = count
inhibit_in  in  NUM_CNT  mcountinhibit bits [3+NUM_CNT-1:3]
csr_data_out  out  32  combinational read data, 0 when not hit
csr_hit_out  out  1  csr_addr_in decodes to a register in this bank
ovf_vec_out  out  NUM_CNT  sticky overflow flags
ovf_irq_out  out  1  registered OR of ovf_vec_out

Behaviour:
- Address map, i = 0..NUM_CNT-1: counter low 0xB03+i, counter high 0xB83+i, event 0x323+i. Any other address: csr_hit_out=0, csr_data_out=0, writes ignored.
- mhpmevent layout: bit31 OF (sticky overflow, R/W), bits[EVT_SEL_W-1:0] selector, all other bits read 0.
- Selector 0 or > NUM_EVT: counter never increments.
- Reset (rst_in low, asynchronous): all counters 0, selectors 0, OF 0, internal event stage 0, ovf_irq_out 0. Release synchronous to clock edge; no count on the first post-reset edge.
- CSR write: new = op01 ? wdata : op10 ? old|wdata : op11 ? old&~wdata : old. Applied only when wr_en_in=1 and op!=00. Updated value readable the next cycle.
- Event pipeline: stage 1 registers evt_q[i] = event_in[sel_i] & ~inhibit_in[i]. Stage 2 increments counter i by 1 when evt_q[i]=1. Event at cycle t becomes visible on read at cycle t+2.
- Write to the low or high half in the same cycle as a pending increment: the write wins and the increment is dropped. The other half is held at its old value; there is no carry into or from the written half that cycle.
- Increment arithmetic: full CNT_WIDTH add; high half holds bits [CNT_WIDTH-1:32].
- CNT_WIDTH=32: high-half address hits, reads 0, writes are ignored.
- Overflow: an increment from all-ones (CNT_WIDTH bits) wraps to 0 and sets OF_i the same edge. A CSR write to event i in that same cycle wins, including writing OF=0.
- OF is sticky; it is cleared only by a CSR write or by reset.
- ovf_irq_out = registered OR(OF), i.e. one cycle after OF changes.
- Changing a selector or inhibit_in takes effect for events sampled from the next edge. An event already in stage 1 still counts.
- Inhibit applies at sampling (stage 1) only.

Decomposition:
- Shared package msrv32_csr_pkg: CSR base addresses (HPMCOUNTER_BASE 0xB03, HPMCOUNTERH_BASE 0xB83, HPMEVENT_BASE 0x323), csr op encodings, OF bit index 31.
- One sub-module, hpm_counter_slice: one counter, its event register, its stage-1 flop and its overflow logic. Generated NUM_CNT times.
- Top level: address decode, write-op ALU, read mux, irq register.

Test Plan:
- Reset then read 0xB03, 0xB83, 0x323 -> all 0; ovf_irq_out=0.
- Write 0x323=2, pulse event_in[1] for 5 cycles -> 0xB03 reads 5, two cycles after the last pulse; counter 1 stays 0.
- Set inhibit_in[0]=1 with events still active -> count frozen; deassert -> counting resumes the cycle after the next sampled event.
- Write 0xB03=0xFFFFFFFF, 0xB83=0xFFFFFFFF, then one event -> counter reads 0, 0x323 bit31=1, ovf_irq_out=1 one cycle later. Clear OF via op11 with 0x80000000 -> ovf_irq_out drops.
- Low-half carry: write 0xB03=0xFFFFFFFF, 0xB83=0, then one event -> low=0, high=1. A write to 0xB03 in the increment cycle -> written value kept, no increment.
- Assert rst_in low mid-count (asynchronous, between edges) -> all outputs 0 immediately. Unmapped address 0xB03+NUM_CNT -> hit=0, data=0.
